mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_mem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a multicycle request
// handshake. Each request is captured in IDLE and completed after a
// fixed number of wait states with a one-cycle mem_ready pulse.
// Misaligned accesses and conflicting read+write requests complete with
// mem_err set and no side effect on the memory.
`timescale 1ns/1ps

module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] adr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        busy
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] adr_q, adr_d;
    logic [31:0]   data_q, data_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem_q [DEPTH];

    logic          op_rd_s;
    logic          op_wr_s;
    logic [AW+1:0] eff_adr_s;
    logic [31:0]   eff_data_s;
    logic [AW-1:0] idx_s;
    logic          mis_s;
    logic          enter_resp_s;
    logic          both_s;
    logic          mem_we_s;

    // Upper address bits only alias; they never select anything.
    logic          unused_adr_s;
    assign unused_adr_s = ^adr[31:AW+2];

    // Operation seen by the datapath: live inputs in IDLE (zero-wait case
    // completes on the capture edge), captured copies afterwards.
    always_comb begin
        if (state_q == ST_IDLE) begin
            op_rd_s    = mem_read;
            op_wr_s    = mem_write;
            eff_adr_s  = adr[AW+1:0];
            eff_data_s = write_data;
        end else begin
            op_rd_s    = rd_q;
            op_wr_s    = wr_q;
            eff_adr_s  = adr_q;
            eff_data_s = data_q;
        end
    end

    assign idx_s = eff_adr_s[AW+1:2];
    assign mis_s = |eff_adr_s[1:0];

    // Next-state logic: request capture, wait countdown, single RESP cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        adr_d        = adr_q;
        data_d       = data_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        enter_resp_s = 1'b0;
        both_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_read && mem_write) begin
                    // Conflicting request: answer with an error right away.
                    state_d      = ST_RESP;
                    enter_resp_s = 1'b1;
                    both_s       = 1'b1;
                end else if (mem_read || mem_write) begin
                    adr_d  = adr[AW+1:0];
                    data_d = write_data;
                    rd_d   = mem_read;
                    wr_d   = mem_write;
                    if (WAIT_INIT == 4'd0) begin
                        state_d      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A count of 0 cannot occur here; treat it like 1 so the
                // FSM can never stall.
                if (cnt_q <= 4'd1) begin
                    state_d      = ST_RESP;
                    cnt_d        = 4'd0;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response qualifier and load data, both settled on the edge into RESP.
    always_comb begin
        err_d   = err_q;
        rdata_d = rdata_q;
        if (enter_resp_s) begin
            err_d = both_s | mis_s;
            if (!both_s && op_rd_s) begin
                rdata_d = mis_s ? 32'd0 : mem_q[idx_s];
            end else begin
                rdata_d = rdata_q;
            end
        end else begin
            err_d = err_q;
        end
    end

    assign mem_we_s = enter_resp_s & ~both_s & op_wr_s & ~mis_s;

    // Control and datapath registers; everything but the array is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= {(AW+2){1'b0}};
            data_q  <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array write port; never written while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            mem_q[idx_s] <= eff_data_s;
        end
    end

    assign read_data = rdata_q;
    assign mem_ready = (state_q == ST_RESP);
    assign mem_err   = (state_q == ST_RESP) & err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (DEPTH=256/WAIT=2 and
// DEPTH=16/WAIT=0) checked every cycle against a transaction-timeline
// model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps

module tb_mem_responder;

    localparam int D0 = 256;
    localparam int W0 = 2;
    localparam int D1 = 16;
    localparam int W1 = 0;

    logic        clk;
    logic        rst_n;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] ad   [2];
    logic [31:0] wd   [2];
    logic [31:0] rdat [2];
    logic        rdy  [2];
    logic        er   [2];
    logic        bsy  [2];

    int total = 0;
    int bad   = 0;

    // Model: each transaction is a start edge and a response edge.
    int          ecnt = 0;
    bit          act   [2];
    int          e0    [2];
    int          ee    [2];
    int          kind  [2];   // 0 read, 1 write, 2 read+write conflict
    logic [31:0] tadr  [2];
    logic [31:0] tdat  [2];
    logic [31:0] exp_rd [2];
    logic [31:0] mm [2][256];

    mem_responder #(.DEPTH(D0), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd[0]), .mem_write(wr[0]),
        .adr(ad[0]), .write_data(wd[0]), .read_data(rdat[0]),
        .mem_ready(rdy[0]), .mem_err(er[0]), .busy(bsy[0])
    );

    mem_responder #(.DEPTH(D1), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd[1]), .mem_write(wr[1]),
        .adr(ad[1]), .write_data(wd[1]), .read_data(rdat[1]),
        .mem_ready(rdy[1]), .mem_err(er[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dep(input int u);
        return (u == 0) ? D0 : D1;
    endfunction

    function automatic int wt(input int u);
        return (u == 0) ? W0 : W1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: accept requests, apply effects on the response edge.
    initial begin
        for (int u = 0; u < 2; u++) begin
            act[u] = 1'b0; exp_rd[u] = 32'd0; e0[u] = 0; ee[u] = 0; kind[u] = 0;
            tadr[u] = 32'd0; tdat[u] = 32'd0;
            for (int i = 0; i < 256; i++) mm[u][i] = 32'd0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int u = 0; u < 2; u++) begin
                    act[u] = 1'b0;
                    exp_rd[u] = 32'd0;
                end
            end else begin
                ecnt++;
                for (int u = 0; u < 2; u++) begin
                    if ((!act[u] || ecnt > ee[u] + 1) && (rd[u] || wr[u])) begin
                        act[u]  = 1'b1;
                        e0[u]   = ecnt;
                        tadr[u] = ad[u];
                        tdat[u] = wd[u];
                        if (rd[u] && wr[u]) begin
                            kind[u] = 2;
                            ee[u]   = ecnt;
                        end else begin
                            kind[u] = rd[u] ? 0 : 1;
                            ee[u]   = ecnt + wt(u);
                        end
                    end
                    if (act[u] && ecnt == ee[u] && kind[u] != 2) begin
                        int idx;
                        idx = int'((tadr[u] >> 2) % 32'(dep(u)));
                        if (kind[u] == 0)
                            exp_rd[u] = (tadr[u][1:0] != 2'b00) ? 32'd0 : mm[u][idx];
                        else if (tadr[u][1:0] == 2'b00)
                            mm[u][idx] = tdat[u];
                    end
                end
            end
        end
    end

    // Compare process: every output of both instances, every cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                logic eb, er_x, ey;
                eb   = act[u] && ecnt >= e0[u] && ecnt <= ee[u];
                ey   = act[u] && ecnt == ee[u];
                er_x = ey && (kind[u] == 2 || tadr[u][1:0] != 2'b00);
                chk($sformatf("busy%0d", u), {31'd0, bsy[u]}, {31'd0, eb});
                chk($sformatf("ready%0d", u), {31'd0, rdy[u]}, {31'd0, ey});
                chk($sformatf("err%0d", u), {31'd0, er[u]}, {31'd0, er_x});
                chk($sformatf("rdata%0d", u), rdat[u], exp_rd[u]);
            end
        end
    end

    // One request, held until mem_ready, bounded wait.
    task automatic txn(input int u, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        rd[u] = r; wr[u] = w; ad[u] = a; wd[u] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[u] && n < 40);
        chk("ready_seen", {31'd0, rdy[u]}, 32'd1);
        rd[u] = 1'b0; wr[u] = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [31:0] a, v;
        for (int u = 0; u < 2; u++) begin
            rd[u] = 1'b0; wr[u] = 1'b0; ad[u] = 32'd0; wd[u] = 32'd0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rdata", rdat[0], 32'd0);
        chk("reset_busy", {31'd0, bsy[0]}, 32'd0);
        #2 rst_n = 1'b1;

        // Fill both memories through the port.
        for (int i = 0; i < D0; i++) begin
            v = $urandom;
            if (i == 4)  v = 32'hDEADBEEF;
            if (i == 12) v = 32'h0BADF00D;
            txn(0, 1'b0, 1'b1, 32'(i * 4), v);
        end
        for (int i = 0; i < D1; i++) txn(1, 1'b0, 1'b1, 32'(i * 4), $urandom);

        // Read of 0x10 with two wait states: exact latency.
        @(negedge clk);
        rd[0] = 1'b1; ad[0] = 32'h10;
        @(negedge clk);
        chk("lat_busy1", {31'd0, bsy[0]}, 32'd1);
        chk("lat_rdy1", {31'd0, rdy[0]}, 32'd0);
        @(negedge clk);
        chk("lat_busy2", {31'd0, bsy[0]}, 32'd1);
        chk("lat_rdy2", {31'd0, rdy[0]}, 32'd0);
        @(negedge clk);
        chk("lat_rdy3", {31'd0, rdy[0]}, 32'd1);
        chk("lat_data", rdat[0], 32'hDEADBEEF);
        chk("lat_err", {31'd0, er[0]}, 32'd0);
        rd[0] = 1'b0;

        // Write then read back, directly and through an alias.
        txn(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
        txn(0, 1'b1, 1'b0, 32'h20, 32'd0);
        chk("wr_rd", rdat[0], 32'h12345678);
        txn(0, 1'b1, 1'b0, 32'h420, 32'd0);
        chk("alias_rd", rdat[0], 32'h12345678);

        // Misaligned read and write.
        txn(0, 1'b1, 1'b0, 32'h13, 32'd0);
        chk("mis_err", {31'd0, er[0]}, 32'd1);
        chk("mis_rdata", rdat[0], 32'd0);
        txn(0, 1'b0, 1'b1, 32'h11, 32'hFFFFFFFF);
        txn(0, 1'b1, 1'b0, 32'h10, 32'd0);
        chk("mis_wr_kept", rdat[0], 32'hDEADBEEF);

        // Read and write together: error pulse after one edge, no effect.
        @(negedge clk);
        rd[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'd0;
        @(negedge clk);
        chk("both_rdy", {31'd0, rdy[0]}, 32'd1);
        chk("both_err", {31'd0, er[0]}, 32'd1);
        chk("both_rdata", rdat[0], 32'hDEADBEEF);
        rd[0] = 1'b0; wr[0] = 1'b0;
        txn(0, 1'b1, 1'b0, 32'h20, 32'd0);
        chk("both_mem", rdat[0], 32'h12345678);

        // Reset during WAIT aborts the write.
        @(negedge clk);
        wr[0] = 1'b1; ad[0] = 32'h30; wd[0] = 32'hA5A5A5A5;
        @(negedge clk);
        chk("abort_busy", {31'd0, bsy[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rdata", rdat[0], 32'd0);
        chk("abort_rdy", {31'd0, rdy[0]}, 32'd0);
        chk("abort_err", {31'd0, er[0]}, 32'd0);
        chk("abort_busy0", {31'd0, bsy[0]}, 32'd0);
        wr[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        txn(0, 1'b1, 1'b0, 32'h30, 32'd0);
        chk("abort_mem", rdat[0], 32'h0BADF00D);

        // Zero wait states, read held high: ready every second cycle.
        @(negedge clk);
        rd[1] = 1'b1; ad[1] = 32'h24;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rdy[1]) pulses++;
        end
        rd[1] = 1'b0;
        chk("b2b_pulses", 32'(pulses), 32'd5);

        // Random traffic on both instances.
        for (int it = 0; it < 400; it++) begin
            int u, op;
            u = int'($urandom_range(0, 1));
            a = $urandom;
            if (u == 0) a[9:6] = 4'd0;
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'(1 + $urandom_range(0, 2));
            else a[1:0] = 2'b00;
            op = int'($urandom_range(0, 9));
            if (op == 0)      txn(u, 1'b1, 1'b1, a, $urandom);
            else if (op < 5)  txn(u, 1'b1, 1'b0, a, $urandom);
            else              txn(u, 1'b0, 1'b1, a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
